// File: rtl/sinegen_phase_acc.sv
// Phase-accumulator address generator for the dual-port sine ROM.
// addr1 is the integer part of the phase; addr2 is addr1 plus a
// configurable offset. Frequency/offset updates are shadowed and committed
// only at a phase wrap or while stalled, so a period is never cut short.
module sinegen_phase_acc #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int FRAC_WIDTH    = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                en,
   input  logic                                cfg_valid,
   output logic                                cfg_ready,
   input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] cfg_incr,
   input  logic [ADDRESS_WIDTH-1:0]            cfg_offset,
   output logic [ADDRESS_WIDTH-1:0]            addr1,
   output logic [ADDRESS_WIDTH-1:0]            addr2,
   output logic                                wrap,
   output logic                                pending
);

   localparam int PW = ADDRESS_WIDTH + FRAC_WIDTH;
   // One ROM address per cycle after reset.
   localparam logic [PW-1:0] INCR_RST = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1, {FRAC_WIDTH{1'b0}}};

   typedef enum logic {READY, PENDING} state_t;

   state_t                   state_r, state_nxt;
   logic [PW-1:0]            phase_r;
   logic [PW-1:0]            incr_r;
   logic [ADDRESS_WIDTH-1:0] offset_r;
   logic [PW-1:0]            sh_incr;
   logic [ADDRESS_WIDTH-1:0] sh_offset;
   logic                     wrap_r;
   logic [PW:0]              sum;
   logic                     carry;
   logic                     accept;
   logic                     commit;

   // Extra top bit of the sum is the wrap indication.
   assign sum   = {1'b0, phase_r} + {1'b0, incr_r};
   assign carry = sum[PW];

   // Phase advances only when enabled; wrap pulses for one step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_r <= '0;
         wrap_r  <= 1'b0;
      end else begin
         if (en) phase_r <= sum[PW-1:0];
         wrap_r <= en & carry;
      end
   end

   // Handshake FSM: accept into shadow, then wait for a safe commit point.
   always_comb begin
      state_nxt = state_r;
      cfg_ready = 1'b0;
      pending   = 1'b0;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state_r)
         READY: begin
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               accept    = 1'b1;
               state_nxt = PENDING;
            end
         end
         PENDING: begin
            pending = 1'b1;
            // Stalled, or the current step wraps (old increment still used
            // for that step since incr_r updates on the same edge).
            if (!en || carry) begin
               commit    = 1'b1;
               state_nxt = READY;
            end
         end
         default: state_nxt = READY;
      endcase
   end

   // Configuration state: shadow capture, commit, FSM register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= READY;
         incr_r    <= INCR_RST;
         offset_r  <= '0;
         sh_incr   <= '0;
         sh_offset <= '0;
      end else begin
         state_r <= state_nxt;
         if (accept) begin
            sh_incr   <= cfg_incr;
            sh_offset <= cfg_offset;
         end
         if (commit) begin
            incr_r   <= sh_incr;
            offset_r <= sh_offset;
         end
      end
   end

   assign addr1 = phase_r[PW-1:FRAC_WIDTH];
   assign addr2 = addr1 + offset_r;
   assign wrap  = wrap_r;

endmodule
